// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared memory port between the sequencer and the memory
interface multicycle_ctrl_if;
    logic mem_req_o;
    logic mem_we_o;
    logic mem_isfetch_o;
    logic mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_isfetch_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_isfetch_o,
        output mem_ack_i
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer over one memory port
module multicycle_ctrl #(
    parameter int TMO_CYC = 16,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [6:0]             opcode_i,
    input  logic                   ctrl_regwren_i,
    input  logic                   ctrl_memren_i,
    input  logic                   ctrl_memwren_i,
    input  logic                   br_taken_i,
    multicycle_ctrl_if.master      mem,
    output logic                   ir_we_o,
    output logic                   pc_we_o,
    output logic                   pcsel_o,
    output logic                   regwren_o,
    output logic                   retire_o,
    output logic [CNT_W-1:0]       insn_cnt_o,
    output logic [2:0]             state_o,
    output logic                   halted_o
);
    localparam int TW = $clog2(TMO_CYC);

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t           state;
    logic [TW-1:0]    tmo_cnt;
    logic             pcsel_q;
    logic             store_q;
    logic [CNT_W-1:0] insn_cnt;
    logic             is_system;
    logic             tmo_last;
    logic             pcsel_next;

    assign is_system = (opcode_i == OP_SYSTEM);
    assign tmo_last  = (tmo_cnt == TW'(TMO_CYC - 1));

    always_comb begin
        pcsel_next = 1'b0;
        case (opcode_i)
            OP_JAL, OP_JALR: pcsel_next = 1'b1;
            OP_BRANCH:       pcsel_next = br_taken_i;
            default:         pcsel_next = 1'b0;
        endcase
    end

    // tmo_cnt only survives a cycle while a request is pending without ack;
    // every other path, including any state change, returns it to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            tmo_cnt  <= '0;
            pcsel_q  <= 1'b0;
            store_q  <= 1'b0;
            insn_cnt <= '0;
        end else begin
            tmo_cnt <= '0;
            case (state)
                S_IDLE: begin
                    if (start_i) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem.mem_ack_i)  state <= S_DECODE;
                    else if (tmo_last)  state <= S_ERROR;
                    else                tmo_cnt <= tmo_cnt + TW'(1);
                end
                S_DECODE: begin
                    if (is_system) begin
                        state    <= S_HALT;
                        insn_cnt <= insn_cnt + CNT_W'(1);
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pcsel_q <= pcsel_next;
                    store_q <= ctrl_memwren_i;
                    state   <= (ctrl_memren_i || ctrl_memwren_i) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (mem.mem_ack_i)  state <= S_WB;
                    else if (tmo_last)  state <= S_ERROR;
                    else                tmo_cnt <= tmo_cnt + TW'(1);
                end
                S_WB: begin
                    insn_cnt <= insn_cnt + CNT_W'(1);
                    state    <= S_FETCH;
                end
                default: state <= state;
            endcase
        end
    end

    // Request lines depend only on registered state so they hold steady while waiting
    // and drop the instant reset is asserted.
    assign mem.mem_req_o     = (state == S_FETCH) || (state == S_MEM);
    assign mem.mem_isfetch_o = (state == S_FETCH);
    assign mem.mem_we_o      = (state == S_MEM) && store_q;

    assign ir_we_o    = (state == S_FETCH) && mem.mem_ack_i;
    assign pc_we_o    = (state == S_WB);
    assign pcsel_o    = (state == S_WB) && pcsel_q;
    assign regwren_o  = (state == S_WB) && ctrl_regwren_i;
    assign retire_o   = (state == S_WB) || ((state == S_DECODE) && is_system);
    assign insn_cnt_o = insn_cnt;
    assign state_o    = state;
    assign halted_o   = (state == S_HALT) || (state == S_ERROR);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [6:0] opcode_i;
    logic       ctrl_regwren_i;
    logic       ctrl_memren_i;
    logic       ctrl_memwren_i;
    logic       br_taken_i;
    logic       ir_we_o;
    logic       pc_we_o;
    logic       pcsel_o;
    logic       regwren_o;
    logic       retire_o;
    logic [3:0] insn_cnt_o;
    logic [2:0] state_o;
    logic       halted_o;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_ctrl_if mem_if();

    multicycle_ctrl #(.TMO_CYC(16), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .opcode_i       (opcode_i),
        .ctrl_regwren_i (ctrl_regwren_i),
        .ctrl_memren_i  (ctrl_memren_i),
        .ctrl_memwren_i (ctrl_memwren_i),
        .br_taken_i     (br_taken_i),
        .mem            (mem_if),
        .ir_we_o        (ir_we_o),
        .pc_we_o        (pc_we_o),
        .pcsel_o        (pcsel_o),
        .regwren_o      (regwren_o),
        .retire_o       (retire_o),
        .insn_cnt_o     (insn_cnt_o),
        .state_o        (state_o),
        .halted_o       (halted_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start_i = 1'b0; opcode_i = 7'h13;
        ctrl_regwren_i = 1'b0; ctrl_memren_i = 1'b0; ctrl_memwren_i = 1'b0;
        br_taken_i = 1'b0; mem_if.mem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("rst_cnt", 32'(insn_cnt_o), 32'd0);
        chk("rst_halted", 32'(halted_o), 32'd0);
        chk("rst_strobes", 32'({ir_we_o, pc_we_o, pcsel_o, regwren_o, retire_o}), 32'd0);

        // 1: reset mid-FETCH drops the request at once
        @(negedge clk); rst = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        chk("t1_fetch_state", 32'(state_o), 32'd1);
        chk("t1_fetch_req", 32'({mem_if.mem_req_o, mem_if.mem_isfetch_o, mem_if.mem_we_o}), 32'b110);
        rst = 1'b0; #1;
        chk("t1_abort_req", 32'(mem_if.mem_req_o), 32'd0);
        chk("t1_abort_state", 32'(state_o), 32'd0);
        chk("t1_abort_cnt", 32'(insn_cnt_o), 32'd0);
        chk("t1_abort_retire", 32'(retire_o), 32'd0);
        @(negedge clk); rst = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0; #1;
        chk("t1_restart", 32'(state_o), 32'd1);

        // 2: ADDI with zero-wait fetch
        opcode_i = 7'h13; ctrl_regwren_i = 1'b1; mem_if.mem_ack_i = 1'b1; #1;
        chk("t2_irwe", 32'(ir_we_o), 32'd1);
        @(negedge clk); mem_if.mem_ack_i = 1'b0; #1;
        chk("t2_decode", 32'(state_o), 32'd2);
        chk("t2_dec_strobes", 32'({ir_we_o, pc_we_o, regwren_o, retire_o}), 32'd0);
        @(negedge clk); #1;
        chk("t2_exec", 32'(state_o), 32'd3);
        @(negedge clk); #1;
        chk("t2_wb", 32'(state_o), 32'd5);
        chk("t2_wb_strobes", 32'({regwren_o, pc_we_o, pcsel_o, retire_o}), 32'b1101);
        chk("t2_wb_cnt", 32'(insn_cnt_o), 32'd0);
        @(negedge clk); #1;
        chk("t2_next_fetch", 32'(state_o), 32'd1);
        chk("t2_cnt", 32'(insn_cnt_o), 32'd1);
        chk("t2_after_strobes", 32'({regwren_o, pc_we_o, retire_o}), 32'd0);

        // 3: SW with ack delayed 3 cycles in MEM
        opcode_i = 7'h23; ctrl_regwren_i = 1'b0; ctrl_memwren_i = 1'b1; mem_if.mem_ack_i = 1'b1;
        @(negedge clk); mem_if.mem_ack_i = 1'b0; #1;
        chk("t3_decode", 32'(state_o), 32'd2);
        @(negedge clk); #1;
        chk("t3_exec", 32'(state_o), 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) mem_if.mem_ack_i = 1'b1;
            #1;
            chk($sformatf("t3_mem%0d_state", i), 32'(state_o), 32'd4);
            chk($sformatf("t3_mem%0d_req", i),
                32'({mem_if.mem_req_o, mem_if.mem_isfetch_o, mem_if.mem_we_o}), 32'b101);
        end
        @(negedge clk); mem_if.mem_ack_i = 1'b0; #1;
        chk("t3_wb", 32'(state_o), 32'd5);
        chk("t3_wb_strobes", 32'({regwren_o, pc_we_o, retire_o}), 32'b011);
        @(negedge clk); #1;
        chk("t3_cnt", 32'(insn_cnt_o), 32'd2);
        chk("t3_fetch", 32'(state_o), 32'd1);
        ctrl_memwren_i = 1'b0;

        // 4: BEQ taken, BNE not taken, JAL
        for (int k = 0; k < 3; k++) begin
            opcode_i   = (k == 2) ? 7'h6F : 7'h63;
            br_taken_i = (k == 0);
            mem_if.mem_ack_i = 1'b1;
            @(negedge clk); mem_if.mem_ack_i = 1'b0;
            @(negedge clk);
            @(negedge clk); br_taken_i = 1'b0; #1;
            chk($sformatf("t4_wb%0d_pcwe", k), 32'(pc_we_o), 32'd1);
            chk($sformatf("t4_wb%0d_pcsel", k), 32'(pcsel_o), (k == 1) ? 32'd0 : 32'd1);
            @(negedge clk); #1;
        end
        chk("t4_cnt", 32'(insn_cnt_o), 32'd5);

        // 5: fetch timeout
        chk("t5_start", 32'(state_o), 32'd1);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk); #1;
            chk($sformatf("t5_wait%0d", i), 32'(state_o), 32'd1);
        end
        @(negedge clk); #1;
        chk("t5_error", 32'(state_o), 32'd7);
        chk("t5_halted", 32'(halted_o), 32'd1);
        chk("t5_req_drop", 32'(mem_if.mem_req_o), 32'd0);
        mem_if.mem_ack_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_absorb", 32'(state_o), 32'd7);
        chk("t5_no_irwe", 32'(ir_we_o), 32'd0);
        chk("t5_cnt", 32'(insn_cnt_o), 32'd5);
        mem_if.mem_ack_i = 1'b0;

        // 6: 16 retires wrap a 4-bit counter, then ECALL halts
        rst = 1'b0;
        @(negedge clk); rst = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        opcode_i = 7'h13; ctrl_regwren_i = 1'b1;
        for (int n = 0; n < 16; n++) begin
            mem_if.mem_ack_i = 1'b1;
            @(negedge clk); mem_if.mem_ack_i = 1'b0;
            @(negedge clk);
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        chk("t6_wrap0", 32'(insn_cnt_o), 32'd0);
        chk("t6_fetch", 32'(state_o), 32'd1);
        opcode_i = 7'h73; ctrl_regwren_i = 1'b0; mem_if.mem_ack_i = 1'b1;
        @(negedge clk); mem_if.mem_ack_i = 1'b0; #1;
        chk("t6_decode", 32'(state_o), 32'd2);
        chk("t6_retire", 32'(retire_o), 32'd1);
        chk("t6_no_pcwe", 32'(pc_we_o), 32'd0);
        @(negedge clk); start_i = 1'b1; #1;
        chk("t6_halt", 32'(state_o), 32'd6);
        chk("t6_halted", 32'(halted_o), 32'd1);
        chk("t6_cnt_wrap", 32'(insn_cnt_o), 32'd1);
        chk("t6_halt_strobes", 32'({retire_o, pc_we_o, regwren_o, mem_if.mem_req_o}), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("t6_absorb", 32'(state_o), 32'd6);
        start_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
